boot_overlay_ctrl: RTL and testbench

- Sits directly downstream of the boot ROM, between the AS2650 core's bus and the boot ROM / external memory data paths.
- Registers the CPU read address and presents it to the ROM as `rom_addr`.
- Overlays ROM data onto the CPU read bus inside the boot window while booting.
- Retires the overlay after a software exit handshake plus a programmable drain, then passes external memory through permanently until reset.

---
 rtl/boot_overlay_ctrl.sv | 147 ++++++++++++++
 tb/tb_boot_overlay_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/boot_overlay_ctrl.sv
// Boot ROM overlay controller.
// Registers the CPU read address toward the boot ROM and steers ROM data onto
// the CPU read bus for memory reads inside the boot window. A keyed I/O write
// arms the exit. After a fixed number of further memory reads the overlay
// drops for good, and only reset brings it back.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   BOOT  | overlay active, waiting for the keyed exit write
//   ARMED | overlay active, counting down drain memory reads
//   RUN   | overlay retired, all reads pass through to external memory
module boot_overlay_ctrl #(
  parameter int unsigned ROM_SIZE    = 170,
  parameter logic [7:0]  EXIT_PORT   = 8'hFE,
  parameter logic [7:0]  EXIT_KEY    = 8'hA5,
  parameter int unsigned DRAIN_READS = 3
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic [14:0] cpu_addr,
  input  logic        cpu_m_io,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_data,
  input  logic [7:0]  ext_data,
  output logic        ext_sel,
  output logic        boot_active
);

  localparam logic [14:0] ROM_LIMIT  = 15'(ROM_SIZE);
  localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_READS);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  drain_cnt_q;
  logic        boot_active_q;

  logic        rd_q;
  logic        wr_q;
  logic        rd_mem_q, rd_mem_d;
  logic [7:0]  rom_addr_q, rom_addr_d;
  logic        sel_rom_q, sel_rom_d;

  logic        rd_start;
  logic        rd_end;
  logic        wr_start;
  logic        exit_hit;
  logic        in_window;

  assign rd_start = cpu_rd & ~rd_q;
  assign rd_end   = ~cpu_rd & rd_q;
  // A write overlapping a read is illegal; the read wins and the write is dropped.
  assign wr_start = cpu_wr & ~wr_q & ~cpu_rd;

  assign in_window = (cpu_addr < ROM_LIMIT);
  assign exit_hit  = wr_start & ~cpu_m_io & (cpu_addr[7:0] == EXIT_PORT) &
                     (cpu_dout == EXIT_KEY);

  // Strobe history for edge detection.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= cpu_rd;
      wr_q <= cpu_wr;
    end
  end

  // Capture address, overlay select and cycle type at the start of each read.
  always_comb begin
    rom_addr_d = rom_addr_q;
    sel_rom_d  = sel_rom_q;
    rd_mem_d   = rd_mem_q;
    if (rd_start) begin
      rom_addr_d = cpu_addr[7:0];
      sel_rom_d  = cpu_m_io & boot_active_q & in_window;
      rd_mem_d   = cpu_m_io;
    end
  end

  // Read-cycle capture registers; held until the next read starts.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= 8'h00;
      sel_rom_q  <= 1'b0;
      rd_mem_q   <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      sel_rom_q  <= sel_rom_d;
      rd_mem_q   <= rd_mem_d;
    end
  end

  // Overlay lifecycle: arm on the keyed write, drain on memory-read ends, then retire.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      drain_cnt_q   <= 4'd0;
      boot_active_q <= 1'b1;
    end else begin
      case (state_q)
        S_BOOT: begin
          if (exit_hit) begin
            state_q     <= S_ARMED;
            drain_cnt_q <= DRAIN_LOAD;
          end
        end
        S_ARMED: begin
          // The cycle that just ended keeps its data; the new state applies from the next read.
          if (rd_end && rd_mem_q) begin
            if (drain_cnt_q <= 4'd1) begin
              state_q       <= S_RUN;
              drain_cnt_q   <= 4'd0;
              boot_active_q <= 1'b0;
            end else begin
              drain_cnt_q <= drain_cnt_q - 4'd1;
            end
          end
        end
        S_RUN: begin
          state_q       <= S_RUN;
          boot_active_q <= 1'b0;
        end
        default: begin
          state_q       <= S_BOOT;
          drain_cnt_q   <= 4'd0;
          boot_active_q <= 1'b1;
        end
      endcase
    end
  end

  assign rom_addr    = rom_addr_q;
  assign cpu_din     = sel_rom_q ? rom_data : ext_data;
  assign ext_sel     = ~sel_rom_q;
  assign boot_active = boot_active_q;

endmodule

// File: tb/tb_boot_overlay_ctrl.sv
// Bench for boot_overlay_ctrl: directed boot/exit scenarios followed by random
// bus traffic, all checked against a transaction-level model of the overlay.
module tb_boot_overlay_ctrl;

  localparam int         ROM_SIZE    = 170;
  localparam logic [7:0] EXIT_PORT   = 8'hFE;
  localparam logic [7:0] EXIT_KEY    = 8'hA5;
  localparam int         DRAIN_READS = 3;

  logic        wb_clk_i = 1'b0;
  logic        rst_n;
  logic [14:0] cpu_addr;
  logic        cpu_m_io;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  ext_data;
  logic        ext_sel;
  logic        boot_active;

  logic [7:0]  rom_mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: 0 = overlay on, waiting for exit; 1 = exit armed; 2 = overlay retired.
  int phase     = 0;
  int remaining = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  assign rom_data = rom_mem[rom_addr];

  boot_overlay_ctrl #(
    .ROM_SIZE   (ROM_SIZE),
    .EXIT_PORT  (EXIT_PORT),
    .EXIT_KEY   (EXIT_KEY),
    .DRAIN_READS(DRAIN_READS)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .rst_n      (rst_n),
    .cpu_addr   (cpu_addr),
    .cpu_m_io   (cpu_m_io),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ext_data   (ext_data),
    .ext_sel    (ext_sel),
    .boot_active(boot_active)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One read cycle; optionally with the write strobe illegally high alongside it.
  task automatic bus_read(input logic [14:0] addr, input logic m_io, input logic with_wr);
    logic       sel;
    logic [7:0] exp_d;
    @(negedge wb_clk_i);
    cpu_addr = addr;
    cpu_m_io = m_io;
    cpu_dout = EXIT_KEY;
    cpu_rd   = 1'b1;
    cpu_wr   = with_wr;
    ext_data = 8'($urandom);
    if (ext_data == rom_mem[addr[7:0]]) ext_data = ~ext_data;
    sel   = m_io && (phase != 2) && (int'(addr) < ROM_SIZE);
    exp_d = sel ? rom_mem[addr[7:0]] : ext_data;
    @(negedge wb_clk_i);
    check_val("rd_rom_addr", 32'(rom_addr), 32'(addr[7:0]));
    check_val("rd_din", 32'(cpu_din), 32'(exp_d));
    check_val("rd_ext_sel", 32'(ext_sel), 32'(!sel));
    check_val("rd_boot_active", 32'(boot_active), 32'(phase != 2));
    cpu_addr = 15'($urandom);
    @(negedge wb_clk_i);
    check_val("rd_addr_held", 32'(rom_addr), 32'(addr[7:0]));
    check_val("rd_din_stable", 32'(cpu_din), 32'(exp_d));
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    if (phase == 1 && m_io) begin
      remaining--;
      if (remaining == 0) phase = 2;
    end
    @(negedge wb_clk_i);
    check_val("post_rd_boot_active", 32'(boot_active), 32'(phase != 2));
  endtask

  task automatic bus_write(input logic [14:0] addr, input logic m_io, input logic [7:0] data);
    @(negedge wb_clk_i);
    cpu_addr = addr;
    cpu_m_io = m_io;
    cpu_dout = data;
    cpu_wr   = 1'b1;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    cpu_wr = 1'b0;
    if (!m_io && addr[7:0] == EXIT_PORT && data == EXIT_KEY && phase == 0) begin
      phase     = 1;
      remaining = DRAIN_READS;
    end
    @(negedge wb_clk_i);
    check_val("post_wr_boot_active", 32'(boot_active), 32'(phase != 2));
  endtask

  // Reset asserted while a memory read is in flight.
  task automatic reset_mid_read(input logic [14:0] addr);
    @(negedge wb_clk_i);
    cpu_addr = addr;
    cpu_m_io = 1'b1;
    cpu_rd   = 1'b1;
    ext_data = 8'($urandom);
    @(negedge wb_clk_i);
    rst_n = 1'b0;
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    phase     = 0;
    remaining = 0;
    #1;
    check_val("rst_rom_addr", 32'(rom_addr), 32'h0);
    check_val("rst_boot_active", 32'(boot_active), 32'h1);
    check_val("rst_ext_sel", 32'(ext_sel), 32'h1);
    check_val("rst_din", 32'(cpu_din), 32'(ext_data));
    @(negedge wb_clk_i);
    rst_n = 1'b1;
  endtask

  function automatic logic [14:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 15'($urandom_range(0, ROM_SIZE - 1));
      1: return 15'(ROM_SIZE - 1);
      2: return 15'(ROM_SIZE);
      3: return 15'(16'h0100 + 16'($urandom_range(0, 255)));
      4: return 15'h0000;
      default: return 15'($urandom);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i * 37 + 192);
    rst_n    = 1'b0;
    cpu_addr = '0;
    cpu_m_io = 1'b0;
    cpu_rd   = 1'b0;
    cpu_wr   = 1'b0;
    cpu_dout = '0;
    ext_data = 8'h3C;
    #12;
    check_val("init_rom_addr", 32'(rom_addr), 32'h0);
    check_val("init_boot_active", 32'(boot_active), 32'h1);
    check_val("init_ext_sel", 32'(ext_sel), 32'h1);
    check_val("init_din", 32'(cpu_din), 32'(ext_data));
    @(negedge wb_clk_i);
    rst_n = 1'b1;

    // Boot-window reads and pass-through cases.
    bus_read(15'h0000, 1'b1, 1'b0);
    bus_read(15'h00A9, 1'b1, 1'b0);
    bus_read(15'h00AA, 1'b1, 1'b0);
    bus_read(15'h0105, 1'b1, 1'b0);
    bus_read(15'h0003, 1'b0, 1'b0);
    // Exit write overlapping a read is ignored.
    bus_read(15'h00FE, 1'b0, 1'b1);
    // Wrong key, wrong port, memory write: all ignored.
    bus_write(15'h00FE, 1'b0, 8'h5A);
    bus_write(15'h00FD, 1'b0, EXIT_KEY);
    bus_write(15'h00FE, 1'b1, EXIT_KEY);
    bus_read(15'h0010, 1'b1, 1'b0);
    bus_read(15'h0010, 1'b1, 1'b0);
    bus_read(15'h0010, 1'b1, 1'b0);
    bus_read(15'h0010, 1'b1, 1'b0);
    // Arm and drain three memory reads.
    bus_write(15'h00FE, 1'b0, EXIT_KEY);
    bus_read(15'h0010, 1'b1, 1'b0);
    bus_read(15'h0010, 1'b1, 1'b0);
    bus_read(15'h0010, 1'b1, 1'b0);
    bus_read(15'h0010, 1'b1, 1'b0);
    // Exit writes in RUN are ignored.
    bus_write(15'h00FE, 1'b0, EXIT_KEY);
    bus_read(15'h0000, 1'b1, 1'b0);

    // Interleaved I/O reads and a repeated exit write during the drain.
    reset_mid_read(15'h0020);
    bus_write(15'h00FE, 1'b0, EXIT_KEY);
    bus_read(15'h0011, 1'b1, 1'b0);
    bus_read(15'h0004, 1'b0, 1'b0);
    bus_write(15'h00FE, 1'b0, EXIT_KEY);
    bus_read(15'h0005, 1'b0, 1'b0);
    bus_read(15'h0012, 1'b1, 1'b0);
    bus_read(15'h0013, 1'b1, 1'b0);
    bus_read(15'h0014, 1'b1, 1'b0);

    // Reset during the second drain read.
    reset_mid_read(15'h0001);
    bus_write(15'h00FE, 1'b0, EXIT_KEY);
    bus_read(15'h0030, 1'b1, 1'b0);
    reset_mid_read(15'h0031);
    bus_read(15'h0000, 1'b1, 1'b0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50) begin
        bus_read(pick_addr(), 1'($urandom_range(0, 3) != 0), 1'b0);
      end else if (r < 80) begin
        if ($urandom_range(0, 1) == 0)
          bus_write(15'h00FE | 15'($urandom_range(0, 127) << 8), 1'b0, EXIT_KEY);
        else
          bus_write(15'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      end else if (r < 84) begin
        bus_read(15'h00FE, 1'b0, 1'b1);
      end else if (r < 87) begin
        reset_mid_read(pick_addr());
      end else begin
        @(negedge wb_clk_i);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
